// File: rtl/jstk2_packet_decoder.sv
// PmodJSTK2 packet decoder: frames SPI bytes into X/Y/buttons with a staleness watchdog.
// Optional 4-tap moving-average output filter enabled by defining JSTK2_FILTER_EN.
module jstk2_packet_decoder #(
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter logic [9:0] CENTER         = 10'd512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       btn_jstk,
  output logic       btn_trig,
  output logic       pkt_valid,
  output logic       pkt_err,
  output logic       stale
);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, UPDATE, ERR, WAIT_END} state_t;

  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [2:0]      byte_cnt;
  logic            ss_d;
  logic [WD_W-1:0] wd;
  logic [7:0]      shadow [4];
  logic [1:0]      btn_sh;

  logic            good;
  logic [9:0]      raw_x;
  logic [9:0]      raw_y;
  logic            clear_now;
  logic            expire;

`ifdef JSTK2_FILTER_EN
  logic [9:0]  hist_x [4];
  logic [9:0]  hist_y [4];
  logic [9:0]  base_x [4];
  logic [9:0]  base_y [4];
  logic [11:0] sum_x;
  logic [11:0] sum_y;
  logic        pend;
`endif

  always_comb begin
    good   = (shadow[1][7:2] == 6'd0) && (shadow[3][7:2] == 6'd0);
    raw_x  = {shadow[1][1:0], shadow[0]};
    raw_y  = {shadow[3][1:0], shadow[2]};
`ifdef JSTK2_FILTER_EN
    clear_now = pend;
`else
    clear_now = (state == UPDATE);
`endif
    // A publish in the same cycle as expiry suppresses the expiry entirely.
    expire = (wd == WD_LAST) && !clear_now;
  end

`ifdef JSTK2_FILTER_EN
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      base_x[i] = expire ? CENTER : hist_x[i];
      base_y[i] = expire ? CENTER : hist_y[i];
    end
    sum_x = {2'b00, hist_x[0]} + {2'b00, hist_x[1]} + {2'b00, hist_x[2]} + {2'b00, hist_x[3]};
    sum_y = {2'b00, hist_y[0]} + {2'b00, hist_y[1]} + {2'b00, hist_y[2]} + {2'b00, hist_y[3]};
  end
`endif

  // NOTE: shadow bytes are not reset; they are only read after a full frame has overwritten them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 3'd0;
      ss_d      <= 1'b1;
      wd        <= '0;
      x_pos     <= CENTER;
      y_pos     <= CENTER;
      btn_jstk  <= 1'b0;
      btn_trig  <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      stale     <= 1'b1;
`ifdef JSTK2_FILTER_EN
      pend      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_x[i] <= CENTER;
        hist_y[i] <= CENTER;
      end
`endif
    end else begin
      // NOTE: non-blocking throughout, so later assignments in this block take priority.
      ss_d      <= ss;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;

      if (wd != WD_MAX) wd <= wd + 1'b1;
      if (expire) begin
        stale    <= 1'b1;
        x_pos    <= CENTER;
        y_pos    <= CENTER;
        btn_jstk <= 1'b0;
        btn_trig <= 1'b0;
`ifdef JSTK2_FILTER_EN
        for (int i = 0; i < 4; i++) begin
          hist_x[i] <= CENTER;
          hist_y[i] <= CENTER;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (ss_d && !ss) begin
            byte_cnt <= 3'd0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (rx_valid) begin
            if (byte_cnt == 3'd4) btn_sh <= rx_byte[1:0];
            else                  shadow[byte_cnt[1:0]] <= rx_byte;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd4) state <= CHECK;
            else if (ss)          state <= ERR;
          end else if (ss) begin
            state <= ERR;
          end
        end
        CHECK:  state <= good ? UPDATE : ERR;
        UPDATE: begin
`ifdef JSTK2_FILTER_EN
          hist_x[0] <= raw_x;
          hist_y[0] <= raw_y;
          for (int i = 1; i < 4; i++) begin
            hist_x[i] <= base_x[i-1];
            hist_y[i] <= base_y[i-1];
          end
          pend <= 1'b1;
`else
          x_pos     <= raw_x;
          y_pos     <= raw_y;
          btn_jstk  <= btn_sh[0];
          btn_trig  <= btn_sh[1];
          pkt_valid <= 1'b1;
          wd        <= '0;
          stale     <= 1'b0;
`endif
          state <= WAIT_END;
        end
        ERR: begin
          pkt_err <= 1'b1;
          state   <= WAIT_END;
        end
        WAIT_END: if (ss) state <= IDLE;
        default:  state <= IDLE;
      endcase

`ifdef JSTK2_FILTER_EN
      // Adder stage: publish the averaged history one cycle after UPDATE.
      if (pend) begin
        pend      <= 1'b0;
        x_pos     <= sum_x[11:2];
        y_pos     <= sum_y[11:2];
        btn_jstk  <= btn_sh[0];
        btn_trig  <= btn_sh[1];
        pkt_valid <= 1'b1;
        wd        <= '0;
        stale     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_jstk2_packet_decoder.sv
// Directed self-checking bench for jstk2_packet_decoder (TIMEOUT_CYCLES=100).
// Define JSTK2_FILTER_EN for both bench and RTL to exercise the filtered build.
module tb_jstk2_packet_decoder;

`ifdef JSTK2_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       btn_jstk;
  logic       btn_trig;
  logic       pkt_valid;
  logic       pkt_err;
  logic       stale;

  int total = 0;
  int bad   = 0;
  int nv    = 0;
  int ne    = 0;
  int nv0;
  int ne0;

  jstk2_packet_decoder #(.TIMEOUT_CYCLES(100), .CENTER(10'd512)) dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .x_pos(x_pos), .y_pos(y_pos), .btn_jstk(btn_jstk), .btn_trig(btn_trig),
    .pkt_valid(pkt_valid), .pkt_err(pkt_err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid) nv++;
      if (pkt_err)   ne++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed frame: byte0 in [7:0] ... byte4 in [39:32]; ss_last raises ss with the final byte.
  task automatic frame(input logic [39:0] d, input int n, input bit ss_last);
    ss = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      rx_byte  = d[8*i +: 8];
      rx_valid = 1'b1;
      if (ss_last && i == n - 1) ss = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (i != n - 1) tick();
    end
  endtask

  task automatic finish_frame();
    repeat (LAT) tick();
    ss = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; ss = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_x", 32'(x_pos), 32'd512);
    check("rst_y", 32'(y_pos), 32'd512);
    check("rst_btn", {30'd0, btn_trig, btn_jstk}, 32'd0);
    check("rst_pv", 32'(pkt_valid), 32'd0);
    check("rst_pe", 32'(pkt_err), 32'd0);
    check("rst_stale", 32'(stale), 32'd1);

`ifdef JSTK2_FILTER_EN
    // X = 0,0,0,1000 with Y held at 512; expected averages hand-computed from a CENTER-filled history.
    frame({8'h00, 8'h02, 8'h00, 8'h00, 8'h00}, 5, 1'b0);
    repeat (LAT - 1) tick();
    check("f_lat", 32'(pkt_valid), 32'd0);
    tick();
    check("f1_pv", 32'(pkt_valid), 32'd1);
    check("f1_x", 32'(x_pos), 32'd384);
    check("f1_y", 32'(y_pos), 32'd512);
    ss = 1'b1; repeat (2) tick();
    frame({8'h00, 8'h02, 8'h00, 8'h00, 8'h00}, 5, 1'b0);
    repeat (LAT) tick();
    check("f2_x", 32'(x_pos), 32'd256);
    ss = 1'b1; repeat (2) tick();
    frame({8'h00, 8'h02, 8'h00, 8'h00, 8'h00}, 5, 1'b0);
    repeat (LAT) tick();
    check("f3_x", 32'(x_pos), 32'd128);
    ss = 1'b1; repeat (2) tick();
    frame({8'h00, 8'h02, 8'h00, 8'h03, 8'hE8}, 5, 1'b0);
    repeat (LAT) tick();
    check("f4_x", 32'(x_pos), 32'd250);
    check("f4_stale", 32'(stale), 32'd0);
    ss = 1'b1; repeat (2) tick();
`else
    // Good frame with exact pkt_valid latency.
    frame({8'h01, 8'h03, 8'hC8, 8'h01, 8'h34}, 5, 1'b0);
    tick();
    check("g1_lat", 32'(pkt_valid), 32'd0);
    tick();
    check("g1_pv", 32'(pkt_valid), 32'd1);
    check("g1_x", 32'(x_pos), 32'h134);
    check("g1_y", 32'(y_pos), 32'h3C8);
    check("g1_jstk", 32'(btn_jstk), 32'd1);
    check("g1_trig", 32'(btn_trig), 32'd0);
    check("g1_stale", 32'(stale), 32'd0);
    ss = 1'b1;
    tick();
    check("g1_pulse", 32'(pkt_valid), 32'd0);
    tick();

    // Byte1 upper bits set: discarded.
    nv0 = nv;
    frame({8'h01, 8'h03, 8'hC8, 8'h05, 8'h34}, 5, 1'b0);
    repeat (2) tick();
    check("b1_pe", 32'(pkt_err), 32'd1);
    check("b1_pv", 32'(pkt_valid), 32'd0);
    check("b1_x", 32'(x_pos), 32'h134);
    check("b1_y", 32'(y_pos), 32'h3C8);
    ss = 1'b1; repeat (2) tick();
    check("b1_nv", nv, nv0);

    // Short frame: ss rises after 3 bytes, then a full frame.
    ne0 = ne;
    frame({8'h00, 8'h00, 8'h11, 8'h01, 8'h22}, 3, 1'b0);
    ss = 1'b1; repeat (3) tick();
    check("s3_ne", ne, ne0 + 1);
    check("s3_x", 32'(x_pos), 32'h134);
    frame({8'h02, 8'h00, 8'hFF, 8'h02, 8'h00}, 5, 1'b0);
    finish_frame();
    check("s3n_x", 32'(x_pos), 32'h200);
    check("s3n_y", 32'(y_pos), 32'h0FF);
    check("s3n_trig", 32'(btn_trig), 32'd1);
    check("s3n_jstk", 32'(btn_jstk), 32'd0);

    // ss rises together with the fifth byte.
    nv0 = nv; ne0 = ne;
    frame({8'h01, 8'h03, 8'hC8, 8'h01, 8'h34}, 5, 1'b1);
    finish_frame();
    check("e5_x", 32'(x_pos), 32'h134);
    check("e5_nv", nv, nv0 + 1);
    check("e5_ne", ne, ne0);

    // Watchdog: 100 cycles without a good packet.
    frame({8'h03, 8'h03, 8'hC8, 8'h01, 8'h34}, 5, 1'b0);
    repeat (LAT) tick();
    check("wd_pv", 32'(pkt_valid), 32'd1);
    check("wd_btn", {30'd0, btn_trig, btn_jstk}, 32'd3);
    ss = 1'b1;
    repeat (99) tick();
    check("wd_99", 32'(stale), 32'd0);
    tick();
    check("wd_100", 32'(stale), 32'd1);
    check("wd_x", 32'(x_pos), 32'd512);
    check("wd_y", 32'(y_pos), 32'd512);
    check("wd_btn0", {30'd0, btn_trig, btn_jstk}, 32'd0);
    frame({8'h01, 8'h03, 8'hC8, 8'h01, 8'h34}, 5, 1'b0);
    finish_frame();
    check("wd_clr", 32'(stale), 32'd0);
    check("wd_clr_x", 32'(x_pos), 32'h134);

    // Reset during byte 2.
    ne0 = ne;
    ss = 1'b0; tick();
    rx_byte = 8'h34; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick();
    rx_byte = 8'h01; rx_valid = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; rx_valid = 1'b0; ss = 1'b1;
    check("mr_x", 32'(x_pos), 32'd512);
    check("mr_y", 32'(y_pos), 32'd512);
    check("mr_stale", 32'(stale), 32'd1);
    check("mr_jstk", 32'(btn_jstk), 32'd0);
    repeat (3) tick();
    check("mr_ne", ne, ne0);
    frame({8'h02, 8'h00, 8'hFF, 8'h02, 8'h00}, 5, 1'b0);
    finish_frame();
    check("mr_fx", 32'(x_pos), 32'h200);
    check("mr_fy", 32'(y_pos), 32'h0FF);
    check("mr_stale0", 32'(stale), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
